mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- Load/store unit in the MEM stage, directly upstream of the word-wide, big-endian data memory.
- Converts MIPS sub-word accesses into the memory's 32-bit word interface:
  - loads: lb/lbu/lh/lhu/lw
  - stores: sb/sh/sw
- Sub-word stores use a two-cycle read-modify-write and stall the pipeline for one cycle.
- Misaligned accesses are trapped without touching memory.

Parameters:
- WORD, 32, data/address width
- MEM_BYTES, 1000, memory size in bytes; addresses above MEM_BYTES-4 flag an error

Ports:
- clk  in  1  pipeline clock; memory writes on negedge
- reset  in  1  reset, asynchronous, active-high
- req_valid  in  1  MEM-stage access request this cycle
- req_write  in  1  1=store, 0=load
- req_size  in  2  0=byte, 1=half, 2=word, 3=illegal
- req_unsigned  in  1  zero-extend loads (lbu/lhu)
- req_addr  in  WORD  byte address from ALU
- req_wdata  in  WORD  store data (rt), value in low bits
- load_data  out  WORD  extended load result to MEM/WB
- stall  out  1  hold IF..MEM stages this cycle
- addr_err  out  1  sticky misalignment/range error flag
- mem_addr  out  WORD  word-aligned address to memory
- mem_wdata  out  WORD  merged write word
- mem_write  out  1  memory write enable
- mem_read  out  1  memory read enable
- mem_rdata  in  WORD  combinational memory read data

Behaviour:
- Reset values: state=IDLE, addr_err=0, internal merge register=0.
  - All outputs combinational from state: stall=0, mem_write=0, mem_read=0, load_data=0 while reset is high.
- Address rules:
  - mem_addr = {req_addr[31:2],2'b00}.
  - Offset off = req_addr[1:0].
  - Byte lanes are big-endian: off 0 -> bits 31:24, off 3 -> 7:0.
  - Half lanes: off 0 -> 31:16, off 2 -> 15:0.
- Misalignment, checked combinationally while req_valid:
  - Half with off[0]=1, word with off!=0, size==3, or req_addr > MEM_BYTES-4.
  - On error: no mem_read or mem_write, load_data=0, stall=0.
  - addr_err set at the next posedge and held until reset.
- States:
  - IDLE
    - Load: mem_read=1. load_data is the selected lane, sign- or zero-extended, in the same cycle (0 latency). No stall.
    - Store word: mem_write=1, mem_wdata=req_wdata, single cycle, no stall.
    - Store byte/half: mem_read=1, stall=1. At posedge, latch mem_rdata into merge_q, and latch off/size/wdata. Go to RMW_WR.
  - RMW_WR
    - mem_write=1, mem_addr=latched word address, stall=0.
    - mem_wdata = merge_q with the target lane replaced by wdata[7:0] or wdata[15:0].
    - Memory commits on this cycle's negedge. Always return to IDLE next posedge.
    - Request inputs are ignored in this state; the pipeline is held, so it represents the same instruction.
- req_valid=0 in IDLE: all enables 0, load_data=0.
- Reset asserted mid-RMW: return to IDLE immediately. mem_write deasserts combinationally, so no partial write occurs.
- Back-to-back sub-word stores: the second is accepted in the IDLE cycle following RMW_WR, so each costs 2 cycles.
- Load immediately after an RMW store to the same word: it sees the merged value, because the write commits at the negedge before the following posedge.

Decomposition:
- Shared package mips_mem_pkg:
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD
  - state enum IDLE/RMW_WR
  - WORD width constant
- One natural sub-module: lane_mux
  - combinational lane select + sign/zero extend for loads
  - lane insert for store merge
  - reused by both paths.

Test Plan:
- Word store/load: sw 0xDEADBEEF @8, then lw @8 -> mem_write one cycle with mem_wdata=0xDEADBEEF, stall=0; load_data=0xDEADBEEF.
- Byte RMW: memory @8=0x11223344, sb 0xAB @10 -> cycle1 stall=1, mem_read=1; cycle2 mem_write=1, mem_wdata=0x1122AB44; lbu @10 -> 0x000000AB; lb @10 -> 0xFFFFFFAB.
- Half store/load: sh 0x8001 @12 on zeroed word -> mem_wdata=0x80010000; lh @12 -> 0xFFFF8001; lhu @12 -> 0x00008001; lhu @14 -> 0x00000000.
- Misalignment: lw @6 and sh @9 -> mem_read=mem_write=0, stall=0, addr_err=1 after posedge and held; cleared only by reset.
- Reset during RMW_WR: assert reset after cycle1 of sb @8 -> mem_write never asserts, state=IDLE, stall=0, word @8 reads 0.
- Back-to-back: sb 0x01 @4, sb 0x02 @5 -> 4 cycles, stall high in cycles 1 and 3; final word @4 = 0x01020000.

Source files
------------

// File: rtl/mips_mem_pkg.sv
// Shared types for the MEM-stage load/store path: access size encodings,
// the store read-modify-write state and the datapath width.
package mips_mem_pkg;

    localparam int WORD = 32;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;
    localparam logic [1:0] SZ_ILL  = 2'd3;

    typedef enum logic {
        IDLE   = 1'b0,
        RMW_WR = 1'b1
    } state_t;

endpackage

// File: rtl/lane_mux.sv
// Big-endian lane select with sign/zero extension for loads, and lane insert for
// store merges; purely combinational, no flow control.
module lane_mux
    import mips_mem_pkg::*;
(
    input  logic [WORD-1:0] word_i,
    input  logic [1:0]      off_i,
    input  logic [1:0]      size_i,
    input  logic            unsigned_i,
    input  logic [15:0]     ins_i,
    output logic [WORD-1:0] ext_o,
    output logic [WORD-1:0] merged_o
);

    logic [4:0]  bsh;
    logic [4:0]  hsh;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        // Offset 0 is the most significant lane, so shift by (3-off) bytes.
        bsh      = {~off_i, 3'b000};
        hsh      = {~off_i[1], 4'b0000};
        byte_sel = 8'(word_i >> bsh);
        half_sel = 16'(word_i >> hsh);
        ext_o    = word_i;
        merged_o = word_i;
        case (size_i)
            SZ_BYTE: begin
                ext_o    = {{(WORD-8){~unsigned_i & byte_sel[7]}}, byte_sel};
                merged_o = (word_i & ~(WORD'(8'hFF) << bsh)) | (WORD'(ins_i[7:0]) << bsh);
            end
            SZ_HALF: begin
                ext_o    = {{(WORD-16){~unsigned_i & half_sel[15]}}, half_sel};
                merged_o = (word_i & ~(WORD'(16'hFFFF) << hsh)) | (WORD'(ins_i) << hsh);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: zero-latency loads and word stores; byte/half stores
// are a two-cycle read-modify-write that stalls the pipeline for the read cycle.
module mem_access_unit #(
    parameter int WORD      = mips_mem_pkg::WORD,
    parameter int MEM_BYTES = 1000
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid,
    input  logic            req_write,
    input  logic [1:0]      req_size,
    input  logic            req_unsigned,
    input  logic [WORD-1:0] req_addr,
    input  logic [WORD-1:0] req_wdata,
    output logic [WORD-1:0] load_data,
    output logic            stall,
    output logic            addr_err,
    output logic [WORD-1:0] mem_addr,
    output logic [WORD-1:0] mem_wdata,
    output logic            mem_write,
    output logic            mem_read,
    input  logic [WORD-1:0] mem_rdata
);
    import mips_mem_pkg::*;

    localparam logic [WORD-1:0] ADDR_MAX = WORD'(MEM_BYTES - 4);

    state_t          state_q, state_d;
    logic [WORD-1:0] merge_q, merge_d;
    logic [WORD-1:0] addr_q, addr_d;
    logic [1:0]      off_q, off_d;
    logic [1:0]      size_q, size_d;
    logic [15:0]     wdata_q, wdata_d;
    logic            addr_err_q, addr_err_d;

    logic [1:0]      off;
    logic [WORD-1:0] word_addr;
    logic            err;

    logic [WORD-1:0] mux_word;
    logic [1:0]      mux_off;
    logic [1:0]      mux_size;
    logic            mux_unsigned;
    logic [15:0]     mux_ins;
    logic [WORD-1:0] mux_ext;
    logic [WORD-1:0] mux_merged;

    assign off       = req_addr[1:0];
    assign word_addr = {req_addr[WORD-1:2], 2'b00};
    assign addr_err  = addr_err_q;

    // Requests are ignored during RMW_WR, so only an IDLE request can fault.
    assign err = req_valid && (state_q == IDLE) &&
                 ((req_size == SZ_ILL) ||
                  ((req_size == SZ_HALF) && off[0]) ||
                  ((req_size == SZ_WORD) && (off != 2'b00)) ||
                  (req_addr > ADDR_MAX));

    always_comb begin
        mux_word     = mem_rdata;
        mux_off      = off;
        mux_size     = req_size;
        mux_unsigned = req_unsigned;
        mux_ins      = req_wdata[15:0];
        if (state_q == RMW_WR) begin
            mux_word = merge_q;
            mux_off  = off_q;
            mux_size = size_q;
            mux_ins  = wdata_q;
        end
    end

    lane_mux u_lane_mux (
        .word_i     (mux_word),
        .off_i      (mux_off),
        .size_i     (mux_size),
        .unsigned_i (mux_unsigned),
        .ins_i      (mux_ins),
        .ext_o      (mux_ext),
        .merged_o   (mux_merged)
    );

    always_comb begin
        state_d    = state_q;
        merge_d    = merge_q;
        addr_d     = addr_q;
        off_d      = off_q;
        size_d     = size_q;
        wdata_d    = wdata_q;
        addr_err_d = addr_err_q | err;
        stall      = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_addr   = word_addr;
        mem_wdata  = req_wdata;
        load_data  = '0;
        case (state_q)
            IDLE: begin
                if (req_valid && !err) begin
                    if (!req_write) begin
                        mem_read  = 1'b1;
                        load_data = mux_ext;
                    end else if (req_size == SZ_WORD) begin
                        mem_write = 1'b1;
                    end else begin
                        mem_read = 1'b1;
                        stall    = 1'b1;
                        state_d  = RMW_WR;
                        merge_d  = mem_rdata;
                        addr_d   = word_addr;
                        off_d    = off;
                        size_d   = req_size;
                        wdata_d  = req_wdata[15:0];
                    end
                end
            end
            RMW_WR: begin
                mem_write = 1'b1;
                mem_addr  = addr_q;
                mem_wdata = mux_merged;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Reset must kill a pending RMW write before the memory's negedge commit.
        if (reset) begin
            stall     = 1'b0;
            mem_read  = 1'b0;
            mem_write = 1'b0;
            load_data = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            merge_q    <= '0;
            addr_q     <= '0;
            off_q      <= 2'b00;
            size_q     <= SZ_BYTE;
            wdata_q    <= '0;
            addr_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            merge_q    <= merge_d;
            addr_q     <= addr_d;
            off_q      <= off_d;
            size_q     <= size_d;
            wdata_q    <= wdata_d;
            addr_err_q <= addr_err_d;
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit against a negedge-write word memory model.
module tb_mem_access_unit;
    import mips_mem_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [31:0] load_data;
    logic        stall;
    logic        addr_err;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_write;
    logic        mem_read;
    logic [31:0] mem_rdata;

    logic [31:0] mem [0:249] = '{default: 32'h0};
    logic        bd_en;
    logic [7:0]  bd_idx;
    logic [31:0] bd_dat;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mem_access_unit dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_write    (req_write),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .load_data    (load_data),
        .stall        (stall),
        .addr_err     (addr_err),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_write    (mem_write),
        .mem_read     (mem_read),
        .mem_rdata    (mem_rdata)
    );

    always @(negedge clk) begin
        if (bd_en)
            mem[bd_idx] <= bd_dat;
        else if (mem_write && (mem_addr < 32'd1000))
            mem[mem_addr[9:2]] <= mem_wdata;
    end

    always_comb begin
        mem_rdata = 32'h0;
        if (mem_addr < 32'd1000)
            mem_rdata = mem[mem_addr[9:2]];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Called at posedge+1; returns at posedge+4, just before the negedge commit.
    task automatic req(input logic v, input logic w, input logic [1:0] sz, input logic u,
                       input logic [31:0] a, input logic [31:0] d);
        req_valid    = v;
        req_write    = w;
        req_size     = sz;
        req_unsigned = u;
        req_addr     = a;
        req_wdata    = d;
        #3;
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic poke(input logic [7:0] idx, input logic [31:0] dat);
        req_valid = 1'b0;
        bd_idx    = idx;
        bd_dat    = dat;
        bd_en     = 1'b1;
        @(negedge clk);
        #1 bd_en = 1'b0;
        next();
    endtask

    initial begin
        bd_en  = 1'b0;
        bd_idx = 8'd0;
        bd_dat = 32'h0;
        reset  = 1'b1;
        req(1'b1, 1'b0, SZ_WORD, 1'b0, 32'd0, 32'h0);
        chk("rst_stall", {31'b0, stall}, 32'd0);
        chk("rst_mem_write", {31'b0, mem_write}, 32'd0);
        chk("rst_mem_read", {31'b0, mem_read}, 32'd0);
        chk("rst_load_data", load_data, 32'h0);
        chk("rst_addr_err", {31'b0, addr_err}, 32'd0);
        #9 reset = 1'b0;
        next();

        // Word store then load
        req(1'b1, 1'b1, SZ_WORD, 1'b0, 32'd8, 32'hDEADBEEF);
        chk("sw_mem_write", {31'b0, mem_write}, 32'd1);
        chk("sw_wdata", mem_wdata, 32'hDEADBEEF);
        chk("sw_addr", mem_addr, 32'd8);
        chk("sw_stall", {31'b0, stall}, 32'd0);
        next();
        req(1'b1, 1'b0, SZ_WORD, 1'b0, 32'd8, 32'h0);
        chk("lw_data", load_data, 32'hDEADBEEF);
        chk("lw_mem_read", {31'b0, mem_read}, 32'd1);
        chk("lw_mem_write", {31'b0, mem_write}, 32'd0);
        next();
        req(1'b0, 1'b0, SZ_WORD, 1'b0, 32'd8, 32'h0);
        chk("idle_mem_read", {31'b0, mem_read}, 32'd0);
        chk("idle_load_data", load_data, 32'h0);
        next();

        // Byte RMW; the second cycle drives an unrelated load that must be ignored
        poke(8'd2, 32'h11223344);
        req(1'b1, 1'b1, SZ_BYTE, 1'b0, 32'd10, 32'h000000AB);
        chk("sb_c1_stall", {31'b0, stall}, 32'd1);
        chk("sb_c1_mem_read", {31'b0, mem_read}, 32'd1);
        chk("sb_c1_mem_write", {31'b0, mem_write}, 32'd0);
        next();
        req(1'b1, 1'b0, SZ_WORD, 1'b0, 32'h40, 32'h0);
        chk("sb_c2_mem_write", {31'b0, mem_write}, 32'd1);
        chk("sb_c2_wdata", mem_wdata, 32'h1122AB44);
        chk("sb_c2_addr", mem_addr, 32'd8);
        chk("sb_c2_stall", {31'b0, stall}, 32'd0);
        chk("sb_c2_mem_read", {31'b0, mem_read}, 32'd0);
        next();
        req(1'b1, 1'b0, SZ_BYTE, 1'b1, 32'd10, 32'h0);
        chk("lbu_10", load_data, 32'h000000AB);
        next();
        req(1'b1, 1'b0, SZ_BYTE, 1'b0, 32'd10, 32'h0);
        chk("lb_10", load_data, 32'hFFFFFFAB);
        next();
        req(1'b1, 1'b0, SZ_BYTE, 1'b0, 32'd11, 32'h0);
        chk("lb_11", load_data, 32'h00000044);
        next();
        req(1'b1, 1'b0, SZ_HALF, 1'b0, 32'd8, 32'h0);
        chk("lh_8", load_data, 32'h00001122);
        next();

        // Half store on a zeroed word; upper wdata bits must not leak in
        poke(8'd3, 32'h0);
        req(1'b1, 1'b1, SZ_HALF, 1'b0, 32'd12, 32'hFFFF8001);
        chk("sh_c1_stall", {31'b0, stall}, 32'd1);
        next();
        req(1'b0, 1'b0, SZ_WORD, 1'b0, 32'd0, 32'h0);
        chk("sh_c2_mem_write", {31'b0, mem_write}, 32'd1);
        chk("sh_c2_wdata", mem_wdata, 32'h80010000);
        next();
        req(1'b1, 1'b0, SZ_HALF, 1'b0, 32'd12, 32'h0);
        chk("lh_12", load_data, 32'hFFFF8001);
        next();
        req(1'b1, 1'b0, SZ_HALF, 1'b1, 32'd12, 32'h0);
        chk("lhu_12", load_data, 32'h00008001);
        next();
        req(1'b1, 1'b0, SZ_HALF, 1'b1, 32'd14, 32'h0);
        chk("lhu_14", load_data, 32'h00000000);
        next();
        req(1'b1, 1'b0, SZ_BYTE, 1'b0, 32'd12, 32'h0);
        chk("lb_12", load_data, 32'hFFFFFF80);
        next();

        // Misalignment and range errors
        req(1'b1, 1'b0, SZ_WORD, 1'b0, 32'd6, 32'h0);
        chk("lw6_mem_read", {31'b0, mem_read}, 32'd0);
        chk("lw6_mem_write", {31'b0, mem_write}, 32'd0);
        chk("lw6_stall", {31'b0, stall}, 32'd0);
        chk("lw6_load_data", load_data, 32'h0);
        chk("lw6_err_before_edge", {31'b0, addr_err}, 32'd0);
        next();
        chk("lw6_err_after_edge", {31'b0, addr_err}, 32'd1);
        req(1'b1, 1'b1, SZ_HALF, 1'b0, 32'd9, 32'h1234);
        chk("sh9_mem_read", {31'b0, mem_read}, 32'd0);
        chk("sh9_mem_write", {31'b0, mem_write}, 32'd0);
        chk("sh9_stall", {31'b0, stall}, 32'd0);
        next();
        req(1'b1, 1'b1, SZ_BYTE, 1'b0, 32'd997, 32'h12);
        chk("sb997_stall", {31'b0, stall}, 32'd0);
        chk("sb997_mem_read", {31'b0, mem_read}, 32'd0);
        next();
        req(1'b1, 1'b0, SZ_ILL, 1'b0, 32'd0, 32'h0);
        chk("size3_mem_read", {31'b0, mem_read}, 32'd0);
        next();
        req(1'b1, 1'b0, SZ_WORD, 1'b0, 32'd996, 32'h0);
        chk("lw996_mem_read", {31'b0, mem_read}, 32'd1);
        chk("lw996_addr", mem_addr, 32'd996);
        next();
        req(1'b0, 1'b0, SZ_WORD, 1'b0, 32'd0, 32'h0);
        chk("err_sticky", {31'b0, addr_err}, 32'd1);
        reset = 1'b1;
        #1;
        chk("err_cleared", {31'b0, addr_err}, 32'd0);
        reset = 1'b0;
        next();

        // Reset in the write cycle of an RMW
        poke(8'd2, 32'h0);
        req(1'b1, 1'b1, SZ_BYTE, 1'b0, 32'd8, 32'h55);
        chk("rstrmw_c1_stall", {31'b0, stall}, 32'd1);
        next();
        req_valid = 1'b0;
        reset = 1'b1;
        #2;
        chk("rstrmw_mem_write", {31'b0, mem_write}, 32'd0);
        chk("rstrmw_stall", {31'b0, stall}, 32'd0);
        chk("rstrmw_state", 32'(dut.state_q), 32'(IDLE));
        @(negedge clk);
        #1;
        chk("rstrmw_mem_word", mem[2], 32'h0);
        reset = 1'b0;
        next();
        req(1'b1, 1'b0, SZ_WORD, 1'b0, 32'd8, 32'h0);
        chk("rstrmw_lw8", load_data, 32'h0);
        next();

        // Back-to-back byte stores into one word
        poke(8'd1, 32'h0);
        req(1'b1, 1'b1, SZ_BYTE, 1'b0, 32'd4, 32'h01);
        chk("b2b_c1_stall", {31'b0, stall}, 32'd1);
        chk("b2b_c1_mem_read", {31'b0, mem_read}, 32'd1);
        next();
        req(1'b0, 1'b0, SZ_WORD, 1'b0, 32'd0, 32'h0);
        chk("b2b_c2_stall", {31'b0, stall}, 32'd0);
        chk("b2b_c2_wdata", mem_wdata, 32'h01000000);
        next();
        req(1'b1, 1'b1, SZ_BYTE, 1'b0, 32'd5, 32'h02);
        chk("b2b_c3_stall", {31'b0, stall}, 32'd1);
        chk("b2b_c3_mem_read", {31'b0, mem_read}, 32'd1);
        next();
        req(1'b0, 1'b0, SZ_WORD, 1'b0, 32'd0, 32'h0);
        chk("b2b_c4_stall", {31'b0, stall}, 32'd0);
        chk("b2b_c4_mem_write", {31'b0, mem_write}, 32'd1);
        chk("b2b_c4_wdata", mem_wdata, 32'h01020000);
        next();
        req(1'b1, 1'b0, SZ_WORD, 1'b0, 32'd4, 32'h0);
        chk("b2b_lw4", load_data, 32'h01020000);
        next();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
